// File: rtl/seq_div64.sv
// -----------------------------------------------------------------------------
// seq_div64 - multi-cycle restoring integer divider
//
// Each clock in RUN does one shift-and-subtract step, so a division takes WIDTH
// steps. The unit sits beside the 64-bit ALU as a long-latency execution unit.
// A start/busy/done handshake connects it to the issuing controller.
//
// Configuration macro: DIV_SIGNED_EN
//   undefined : unsigned operands. No sign logic is built.
//   defined   : two's complement operands. Magnitudes are divided, then the
//               quotient is negated if the operand signs differ, and the
//               remainder takes the sign of the dividend.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request, sampled only while idle
//   dividend     in   WIDTH  numerator, captured when start is accepted
//   divisor      in   WIDTH  denominator, captured when start is accepted
//   busy         out  1      high while a division is in RUN or DONE
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  quotient, held until the next result
//   remainder    out  WIDTH  remainder, held until the next result
//   div_by_zero  out  1      captured divisor was zero, held with results
// -----------------------------------------------------------------------------
module seq_div64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;     // partial remainder R
  logic [WIDTH-1:0] r_quo;     // working quotient Q (starts as dividend)
  logic [WIDTH-1:0] r_div;     // captured divisor (magnitude in signed build)
  logic             r_dbz;     // captured divisor was zero

  logic [WIDTH:0]   w_shift;   // {R,Q} shifted left by one, upper WIDTH+1 bits
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_final;
  logic [WIDTH-1:0] w_rem_final;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic r_neg_quo;   // operand signs differed
  logic r_neg_rem;   // dividend was negative

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  // Operand magnitudes at accept, plus the sign fix-up applied to the results.
  // On a zero divisor Q already holds all ones and is passed through unchanged.
  // R holds |dividend|, so the sign fix-up turns it back into the dividend.
  always_comb begin
    w_dvd_mag = magnitude(dividend);
    w_dvs_mag = magnitude(divisor);
    if (r_dbz || !r_neg_quo) begin
      w_quo_final = r_quo;
    end else begin
      w_quo_final = negate(r_quo);
    end
    if (r_neg_rem) begin
      w_rem_final = negate(r_rem);
    end else begin
      w_rem_final = r_rem;
    end
  end
`else
  // In the unsigned build, operands and results pass straight through.
  always_comb begin
    w_dvd_mag   = dividend;
    w_dvs_mag   = divisor;
    w_quo_final = r_quo;
    w_rem_final = r_rem;
  end
`endif

  // One restoring step. The compare is WIDTH+1 bits wide, so the bit shifted
  // out of R still counts. When w_ge is set, the difference is below the
  // divisor, so its low WIDTH bits give the exact result.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    if (w_ge) begin
      w_rem_next = w_shift[WIDTH-1:0] - r_div;
      w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_next = w_shift[WIDTH-1:0];
      w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_div       <= {WIDTH{1'b0}};
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_quo   <= 1'b0;
      r_neg_rem   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            r_div       <= w_dvs_mag;
            r_rem       <= {WIDTH{1'b0}};
            r_cnt       <= CNT_LAST;
`ifdef DIV_SIGNED_EN
            r_neg_quo   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_rem   <= dividend[WIDTH-1];
`endif
            if (divisor == {WIDTH{1'b0}}) begin
              // Skip RUN: Q is forced to all ones, and R carries the dividend out.
              r_dbz   <= 1'b1;
              r_quo   <= {WIDTH{1'b1}};
              r_rem   <= w_dvd_mag;
              r_state <= S_DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_quo   <= w_dvd_mag;
              r_state <= S_RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == {CW{1'b0}}) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          quotient    <= w_quo_final;
          remainder   <= w_rem_final;
          div_by_zero <= r_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
